// File: rtl/rob_retire_pkg.sv
// Shared types and widths for the reorder buffer / retirement unit.
// Machine-wide macros get defaults here when the build does not supply them.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 4
`endif
`ifndef PRF_WIDTH
`define PRF_WIDTH 6
`endif
`ifndef ARF_DEPTH
`define ARF_DEPTH 32
`endif

package rob_retire_pkg;

    localparam int ROB_DEPTH_DEF = 32;
    localparam int MW = `MACHINE_WIDTH;
    localparam int RCW = $clog2(MW + 1);

    typedef struct packed {
        logic [4:0]            arn;
        logic [`PRF_WIDTH-1:0] prn;
        logic [`PRF_WIDTH-1:0] prn_prev;
        logic                  wr;
        logic                  done;
        logic                  mispred;
    } rob_entry_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire-lane selection over the head window: in-order, stops after
// the first not-ready/not-done lane and after a firing mispredict.
module rob_retire_sel
    import rob_retire_pkg::*;
(
    input  logic [MW-1:0]  occ,
    input  logic [MW-1:0]  done,
    input  logic [MW-1:0]  mispred,
    input  logic [MW-1:0]  ready,
    output logic [MW-1:0]  fire,
    output logic [RCW-1:0] cnt,
    output logic           mis_hit
);

    logic ok;

    always_comb begin
        fire    = '0;
        cnt     = '0;
        mis_hit = 1'b0;
        ok      = 1'b1;
        for (int i = 0; i < MW; i++) begin
            fire[i] = ok && occ[i] && done[i] && ready[i];
            if (fire[i]) begin
                cnt = cnt + RCW'(1);
                if (mispred[i]) begin
                    mis_hit = 1'b1;
                    ok      = 1'b0;
                end
            end else begin
                ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer with in-order multi-lane retirement, architectural RAT
// and drain-on-mispredict recovery.
module rob_retire
    import rob_retire_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int ROB_WIDTH = $clog2(ROB_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [MW-1:0]                         disp_valid,
    output logic [MW-1:0]                         disp_ready,
    input  logic [MW-1:0][4:0]                    disp_arn,
    input  logic [MW-1:0][`PRF_WIDTH-1:0]         disp_prn,
    input  logic [MW-1:0][`PRF_WIDTH-1:0]         disp_prn_prev,
    input  logic [MW-1:0]                         disp_wr,
    output logic [MW-1:0][ROB_WIDTH-1:0]          disp_rob_idx,
    input  logic [MW-1:0]                         cmpl_valid,
    input  logic [MW-1:0][ROB_WIDTH-1:0]          cmpl_rob_idx,
    input  logic [MW-1:0]                         cmpl_mispred,
    output logic [MW-1:0][`PRF_WIDTH-1:0]         retire_prn_prev,
    output logic [MW-1:0]                         retire_prn_prev_valid,
    input  logic [MW-1:0]                         retire_prn_prev_ready,
    output logic [`ARF_DEPTH-1:0][`PRF_WIDTH-1:0] arch_rat,
    output logic                                  recov_arch_st
);

    localparam int CW = ROB_WIDTH + 1;

    rob_entry_t           rob_q [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] occ_q;
    logic [ROB_WIDTH-1:0] head_q;
    logic [ROB_WIDTH-1:0] tail_q;
    logic [CW-1:0]        count_q;

    logic [CW-1:0]                free_slots;
    logic [CW-1:0]                disp_cnt;
    logic [MW-1:0]                disp_fire;
    logic [MW-1:0][ROB_WIDTH-1:0] win_idx;
    logic [MW-1:0]                win_occ;
    logic [MW-1:0]                win_done;
    logic [MW-1:0]                win_mis;
    logic [MW-1:0]                ret_fire;
    logic [RCW-1:0]               ret_cnt;
    logic                         mis_hit;

    always_comb begin
        free_slots            = CW'(ROB_DEPTH) - count_q;
        disp_cnt              = '0;
        disp_ready            = '0;
        disp_fire             = '0;
        disp_rob_idx          = '0;
        win_idx               = '0;
        win_occ               = '0;
        win_done              = '0;
        win_mis               = '0;
        retire_prn_prev       = '0;
        retire_prn_prev_valid = '0;
        for (int i = 0; i < MW; i++) begin
            disp_ready[i]   = !recov_arch_st && (free_slots > CW'(i));
            disp_rob_idx[i] = tail_q + ROB_WIDTH'(i);
            disp_fire[i]    = disp_valid[i] && disp_ready[i];
            disp_cnt        = disp_cnt + CW'(disp_fire[i]);
            win_idx[i]      = head_q + ROB_WIDTH'(i);
            win_occ[i]      = occ_q[win_idx[i]];
            win_done[i]     = rob_q[win_idx[i]].done;
            win_mis[i]      = rob_q[win_idx[i]].mispred;
            retire_prn_prev[i]       = rob_q[win_idx[i]].prn_prev;
            retire_prn_prev_valid[i] = ret_fire[i] && rob_q[win_idx[i]].wr;
        end
    end

    rob_retire_sel u_sel (
        .occ     (win_occ),
        .done    (win_done),
        .mispred (win_mis),
        .ready   (retire_prn_prev_ready),
        .fire    (ret_fire),
        .cnt     (ret_cnt),
        .mis_hit (mis_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ROB_DEPTH; k++) rob_q[k] <= '0;
            occ_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            recov_arch_st <= 1'b0;
            arch_rat      <= '0;
        end else begin
            // Ascending lane order lets the youngest retiring writer win.
            for (int i = 0; i < MW; i++) begin
                if (retire_prn_prev_valid[i] && rob_q[win_idx[i]].arn != 5'd0)
                    arch_rat[rob_q[win_idx[i]].arn] <= rob_q[win_idx[i]].prn;
            end
            if (mis_hit) begin
                occ_q         <= '0;
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
                recov_arch_st <= 1'b1;
            end else begin
                recov_arch_st <= 1'b0;
                for (int i = 0; i < MW; i++) begin
                    if (ret_fire[i]) occ_q[win_idx[i]] <= 1'b0;
                end
                for (int i = 0; i < MW; i++) begin
                    if (cmpl_valid[i] && occ_q[cmpl_rob_idx[i]]) begin
                        rob_q[cmpl_rob_idx[i]].done    <= 1'b1;
                        rob_q[cmpl_rob_idx[i]].mispred <=
                            rob_q[cmpl_rob_idx[i]].mispred | cmpl_mispred[i];
                    end
                end
                for (int i = 0; i < MW; i++) begin
                    if (disp_fire[i]) begin
                        rob_q[disp_rob_idx[i]] <= '{
                            arn:      disp_arn[i],
                            prn:      disp_prn[i],
                            prn_prev: disp_prn_prev[i],
                            wr:       disp_wr[i],
                            done:     1'b0,
                            mispred:  1'b0
                        };
                        occ_q[disp_rob_idx[i]] <= 1'b1;
                    end
                end
                head_q  <= head_q + ROB_WIDTH'(ret_cnt);
                tail_q  <= tail_q + ROB_WIDTH'(disp_cnt);
                count_q <= count_q + disp_cnt - CW'(ret_cnt);
            end
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: dispatch, completion order, retire
// gating, arch_rat collisions, mispredict drain and pointer wrap.
module tb_rob_retire;
    import rob_retire_pkg::*;

    localparam int RW = 5;
    localparam int PW = `PRF_WIDTH;

    logic                             clk = 1'b0;
    logic                             rst_n;
    logic [MW-1:0]                    disp_valid;
    logic [MW-1:0]                    disp_ready;
    logic [MW-1:0][4:0]               disp_arn;
    logic [MW-1:0][PW-1:0]            disp_prn;
    logic [MW-1:0][PW-1:0]            disp_prn_prev;
    logic [MW-1:0]                    disp_wr;
    logic [MW-1:0][RW-1:0]            disp_rob_idx;
    logic [MW-1:0]                    cmpl_valid;
    logic [MW-1:0][RW-1:0]            cmpl_rob_idx;
    logic [MW-1:0]                    cmpl_mispred;
    logic [MW-1:0][PW-1:0]            retire_prn_prev;
    logic [MW-1:0]                    retire_prn_prev_valid;
    logic [MW-1:0]                    retire_prn_prev_ready;
    logic [`ARF_DEPTH-1:0][PW-1:0]    arch_rat;
    logic                             recov_arch_st;

    int n_chk  = 0;
    int n_pass = 0;
    int tail   = 0;
    int ptail  = 0;
    int pn     = 0;

    always #5 clk = ~clk;

    rob_retire dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .disp_valid            (disp_valid),
        .disp_ready            (disp_ready),
        .disp_arn              (disp_arn),
        .disp_prn              (disp_prn),
        .disp_prn_prev         (disp_prn_prev),
        .disp_wr               (disp_wr),
        .disp_rob_idx          (disp_rob_idx),
        .cmpl_valid            (cmpl_valid),
        .cmpl_rob_idx          (cmpl_rob_idx),
        .cmpl_mispred          (cmpl_mispred),
        .retire_prn_prev       (retire_prn_prev),
        .retire_prn_prev_valid (retire_prn_prev_valid),
        .retire_prn_prev_ready (retire_prn_prev_ready),
        .arch_rat              (arch_rat),
        .recov_arch_st         (recov_arch_st)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        disp_valid    = '0;
        disp_arn      = '0;
        disp_prn      = '0;
        disp_prn_prev = '0;
        disp_wr       = '0;
        cmpl_valid    = '0;
        cmpl_rob_idx  = '0;
        cmpl_mispred  = '0;
    endtask

    task automatic disp(input int lane, input int arn, input int prn,
                        input int prev, input logic wr);
        disp_valid[lane]    = 1'b1;
        disp_arn[lane]      = 5'(arn);
        disp_prn[lane]      = PW'(prn);
        disp_prn_prev[lane] = PW'(prev);
        disp_wr[lane]       = wr;
    endtask

    task automatic cmpl(input int lane, input int idx, input logic mis);
        cmpl_valid[lane]   = 1'b1;
        cmpl_rob_idx[lane] = RW'(idx);
        cmpl_mispred[lane] = mis;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        retire_prn_prev_ready = 4'b1111;
        #1;
        chk("rst_ready", disp_ready, 4'b1111);
        chk("rst_rvalid", retire_prn_prev_valid, 4'b0000);
        chk("rst_recov", recov_arch_st, 1'b0);
        chk("rst_rat1", arch_rat[1], 0);
        tick();
        rst_n = 1'b1;
        tick();

        // basic 4-lane dispatch / complete / retire
        for (int i = 0; i < 4; i++) disp(i, i + 1, 33 + i, 0, 1'b1);
        #1;
        chk("idx0", disp_rob_idx, {5'd3, 5'd2, 5'd1, 5'd0});
        tick();
        clr();
        for (int i = 0; i < 4; i++) cmpl(i, i, 1'b0);
        #1;
        chk("early_rvalid", retire_prn_prev_valid, 4'b0000);
        tick();
        clr();
        #1;
        chk("ret4_valid", retire_prn_prev_valid, 4'b1111);
        chk("ret4_prev", retire_prn_prev, 24'h0);
        tick();
        for (int i = 1; i <= 4; i++) chk("rat_basic", arch_rat[i], 32 + i);

        // fill 32 entries at idx 4..35 (mod 32); j = 4*b+i
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 4; i++)
                disp(i, 7, 20 + 4 * b + i, 8 + 4 * b + i, 1'b1);
            tick();
            clr();
        end
        #1;
        chk("full_ready", disp_ready, 4'b0000);
        cmpl(0, 4, 1'b0);
        cmpl(1, 5, 1'b0);
        tick();
        clr();
        #1;
        chk("ret2_valid", retire_prn_prev_valid, 4'b0011);
        chk("ret2_prev0", retire_prn_prev[0], 8);
        chk("ret2_prev1", retire_prn_prev[1], 9);
        tick();
        chk("after2_ready", disp_ready, 4'b0011);
        chk("rat7_a", arch_rat[7], 21);

        // out-of-order completion: head is 6
        cmpl(0, 8, 1'b0);
        tick();
        clr();
        #1;
        chk("ooo_wait2", retire_prn_prev_valid, 4'b0000);
        cmpl(0, 7, 1'b0);
        tick();
        clr();
        #1;
        chk("ooo_wait1", retire_prn_prev_valid, 4'b0000);
        cmpl(0, 6, 1'b0);
        tick();
        clr();
        #1;
        chk("ooo_ret3", retire_prn_prev_valid, 4'b0111);
        tick();

        // ready gating: head is 9; lane1 not ready
        for (int i = 0; i < 4; i++) cmpl(i, 9 + i, 1'b0);
        tick();
        clr();
        retire_prn_prev_ready = 4'b1101;
        #1;
        chk("rdy_lane0", retire_prn_prev_valid, 4'b0001);
        tick();
        retire_prn_prev_ready = 4'b1111;
        #1;
        chk("rdy_rest", retire_prn_prev_valid, 4'b0111);
        tick();

        // mispredict on lane 1: head is 13, count is 23
        cmpl(0, 13, 1'b0);
        cmpl(1, 14, 1'b1);
        cmpl(2, 15, 1'b0);
        cmpl(3, 16, 1'b0);
        tick();
        clr();
        disp(0, 9, 60, 1, 1'b1);
        #1;
        chk("mis_valid", retire_prn_prev_valid, 4'b0011);
        chk("mis_prev1", retire_prn_prev[1], 18);
        tick();
        clr();
        #1;
        chk("recov_hi", recov_arch_st, 1'b1);
        chk("recov_ready", disp_ready, 4'b0000);
        chk("recov_rvalid", retire_prn_prev_valid, 4'b0000);
        chk("recov_rat7", arch_rat[7], 30);
        chk("recov_rat9", arch_rat[9], 0);
        tick();
        cmpl(0, 15, 1'b0);
        #1;
        chk("recov_lo", recov_arch_st, 1'b0);
        chk("post_ready", disp_ready, 4'b1111);
        tick();
        clr();
        #1;
        chk("drained", retire_prn_prev_valid, 4'b0000);

        // arn collision on lanes 0 and 2; lane1 has no destination
        disp(0, 5, 40, 1, 1'b1);
        disp(1, 6, 42, 2, 1'b0);
        disp(2, 5, 41, 3, 1'b1);
        disp(3, 8, 43, 4, 1'b1);
        #1;
        chk("idx_reset", disp_rob_idx, {5'd3, 5'd2, 5'd1, 5'd0});
        tick();
        clr();
        for (int i = 0; i < 4; i++) cmpl(i, i, 1'b0);
        tick();
        clr();
        #1;
        chk("col_valid", retire_prn_prev_valid, 4'b1101);
        chk("col_prev3", retire_prn_prev[3], 4);
        tick();
        chk("col_rat5", arch_rat[5], 41);
        chk("col_rat6", arch_rat[6], 0);
        chk("col_rat8", arch_rat[8], 43);
        chk("col_rat7", arch_rat[7], 30);

        // advance tail from 4 to 30 with no-destination filler
        tail = 4;
        pn   = 0;
        for (int b = 0; b < 7; b++) begin
            int n;
            n = (b == 6) ? 2 : 4;
            for (int i = 0; i < n; i++) disp(i, 0, 0, 0, 1'b0);
            for (int i = 0; i < pn; i++) cmpl(i, (ptail + i) % 32, 1'b0);
            ptail = tail;
            pn    = n;
            tail  = tail + n;
            tick();
            clr();
        end
        for (int i = 0; i < pn; i++) cmpl(i, (ptail + i) % 32, 1'b0);
        tick();
        clr();
        tick();
        tick();
        tick();
        #1;
        chk("wrap_empty", retire_prn_prev_valid, 4'b0000);
        for (int i = 0; i < 4; i++) disp(i, 10 + i, 50 + i, 11 + i, 1'b1);
        #1;
        chk("wrap_idx", disp_rob_idx, {5'd1, 5'd0, 5'd31, 5'd30});
        tick();
        clr();
        cmpl(0, 30, 1'b0);
        cmpl(1, 31, 1'b0);
        cmpl(2, 0, 1'b0);
        cmpl(3, 1, 1'b0);
        tick();
        clr();
        #1;
        chk("wrap_valid", retire_prn_prev_valid, 4'b1111);
        chk("wrap_prev1", retire_prn_prev[1], 12);
        tick();
        chk("wrap_rat13", arch_rat[13], 53);

        // reset mid-operation
        disp(0, 3, 44, 5, 1'b1);
        tick();
        clr();
        rst_n = 1'b0;
        #1;
        chk("rst2_rat5", arch_rat[5], 0);
        chk("rst2_ready", disp_ready, 4'b1111);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("rst2_idx", disp_rob_idx, {5'd3, 5'd2, 5'd1, 5'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
